// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - shared types, constants and helpers for the sequential FP adder
//
// Purpose : FSM state enum, IEEE-754 single field widths, bias and quiet-NaN
//           constants, plus packing and special-operand helper functions.
// Ports   : none (package)
package fp_add_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam int EXP_MAX = 2 * BIAS + 1;  // all-ones exponent (inf/NaN)
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_e;

  // Packs a normalized result; exponent overflow saturates to signed infinity
  // and underflow flushes to signed zero.
  function automatic logic [31:0] fp_pack(input logic s,
                                          input logic signed [9:0] e,
                                          input logic [MAN_W-1:0] f);
    if (e >= 10'(EXP_MAX)) return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (e <= 10'sd0)  return {s, 31'd0};
    else                   return {s, e[EXP_W-1:0], f};
  endfunction

  // Result when at least one operand has an all-ones exponent.
  // b_eff already carries the sign flip for subtraction.
  function automatic logic [31:0] fp_special(input logic [31:0] a_v,
                                             input logic [31:0] b_eff);
    logic a_max, b_max, a_nan, b_nan;
    a_max = (a_v[30:23] == 8'hFF);
    b_max = (b_eff[30:23] == 8'hFF);
    a_nan = a_max && (a_v[22:0] != 23'd0);
    b_nan = b_max && (b_eff[22:0] != 23'd0);
    if (a_nan || b_nan || (a_max && b_max && (a_v[31] != b_eff[31])))
      return QNAN;
    else if (a_max)
      return {a_v[31], 8'hFF, 23'd0};
    else
      return {b_eff[31], 8'hFF, 23'd0};
  endfunction

endpackage

// File: rtl/fp_lzc24.sv
// rtl/fp_lzc24.sv - combinational leading-zero count of a 24-bit mantissa
//
// Purpose : counts zeros above the most significant set bit; 24 when all zero.
// Ports   : man_i [23:0] mantissa in
//           lz_o  [4:0]  leading-zero count, 0..24
module fp_lzc24 (
  input  logic [23:0] man_i,
  output logic [4:0]  lz_o
);

  // Ascending scan so the highest set bit is the last to write the count.
  always_comb begin
    lz_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (man_i[i]) lz_o = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// rtl/fp_add_seq.sv - multi-cycle IEEE-754 single add/subtract with truncation
//
// Purpose : IDLE -> ALIGN -> ADD -> NORM -> DONE datapath with bounded shifts
//           per cycle. Optional macro FP_ADD_SEQ_SPECIALS_EN routes inf/NaN
//           operands straight to DONE; without it they are ordinary numbers.
// Ports   : clk, rst_n (sync, active low)
//           in_valid/in_ready, a, b, op_sub   operand handshake
//           out_valid/out_ready, result       result handshake
//           busy                              high outside IDLE
module fp_add_seq
  import fp_add_pkg::*;
#(
  parameter int ALIGN_STEP = 8,
  parameter int NORM_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  localparam logic [7:0] ASTEP = 8'(ALIGN_STEP);
  localparam logic [4:0] NSTEP = 5'(NORM_STEP);

  state_e            state_q;
  logic              sa_q, eff_sub_q;
  logic signed [9:0] exp_q;
  logic [23:0]       ma_q, mb_q;
  logic [24:0]       sum_q;
  logic [7:0]        diff_q;
  logic [31:0]       result_q;
  logic              out_valid_q, busy_q, in_ready_q;

  // Operand unpack and magnitude ordering
  logic              sa, sb, swap;
  logic [EXP_W-1:0]  ea, eb;
  logic [23:0]       ma, mb;

  always_comb begin
    sa   = a[31];
    sb   = b[31] ^ op_sub;
    ea   = a[30:23];
    eb   = b[30:23];
    ma   = (ea != '0) ? {1'b1, a[22:0]} : 24'd0;  // exp 0 flushes to zero
    mb   = (eb != '0) ? {1'b1, b[22:0]} : 24'd0;
    swap = {eb, mb} > {ea, ma};
  end

  // Alignment step: a difference of 25 or more leaves nothing of B
  logic [7:0]  ashamt, diff_d;
  logic [23:0] mb_d;

  always_comb begin
    ashamt = (diff_q > ASTEP) ? ASTEP : diff_q;
    if (diff_q >= 8'd25) begin
      mb_d   = 24'd0;
      diff_d = 8'd0;
    end else begin
      mb_d   = mb_q >> ashamt;
      diff_d = diff_q - ashamt;
    end
  end

  // A is the larger magnitude, so the subtraction never goes negative
  logic [24:0] sum_d;
  assign sum_d = eff_sub_q ? ({1'b0, ma_q} - {1'b0, mb_q})
                           : ({1'b0, ma_q} + {1'b0, mb_q});

  // Normalization step
  logic [4:0]        lz, nshamt;
  logic [23:0]       m_norm;
  logic signed [9:0] e_norm;

  fp_lzc24 u_lzc (
    .man_i (sum_q[23:0]),
    .lz_o  (lz)
  );

  always_comb begin
    nshamt = (lz > NSTEP) ? NSTEP : lz;
    m_norm = sum_q[23:0] << nshamt;
    e_norm = exp_q - $signed({5'd0, nshamt});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sa_q        <= 1'b0;
      eff_sub_q   <= 1'b0;
      exp_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      sum_q       <= '0;
      diff_q      <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef FP_ADD_SEQ_SPECIALS_EN
            if ((ea == 8'hFF) || (eb == 8'hFF)) begin
              result_q    <= fp_special(a, {sb, b[30:0]});
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
`else
            begin
`endif
              sa_q      <= swap ? sb : sa;
              eff_sub_q <= sa ^ sb;
              exp_q     <= $signed({2'b00, swap ? eb : ea});
              ma_q      <= swap ? mb : ma;
              mb_q      <= swap ? ma : mb;
              diff_q    <= swap ? (eb - ea) : (ea - eb);
              state_q   <= ALIGN;
            end
          end
        end
        ALIGN: begin
          mb_q   <= mb_d;
          diff_q <= diff_d;
          if (diff_d == 8'd0) state_q <= ADD;
        end
        ADD: begin
          sum_q   <= sum_d;
          state_q <= NORM;
        end
        NORM: begin
          if (sum_q[24]) begin
            result_q    <= fp_pack(sa_q, exp_q + 10'sd1, sum_q[23:1]);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (sum_q == 25'd0) begin
            result_q    <= 32'h0000_0000;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            sum_q <= {1'b0, m_norm};
            exp_q <= e_norm;
            // Stop early once the exponent is exhausted; the result is zero anyway
            if (m_norm[23] || (e_norm <= 10'sd0)) begin
              result_q    <= fp_pack(sa_q, e_norm, m_norm[22:0]);
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fp_add_seq.sv
// tb/tb_fp_add_seq.sv - directed self-checking bench for fp_add_seq
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, op_sub, out_valid, out_ready, busy;
  logic [31:0] a, b, result;
  int          total = 0;
  int          bad   = 0;
  int          lat;

  always #5 clk = ~clk;

  fp_add_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic start_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sv);
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    a = av; b = bv; op_sub = sv; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic finish_op(input string tag);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input logic sv, input logic [31:0] exp_res, input int exp_lat);
    int l;
    start_op(tag, av, bv, sv);
    wait_done(l);
    chk({tag, "_lat"}, 32'(l), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    finish_op(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run("one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3);
    run("one_minus_one",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3);
    run("diff30",         32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 3);
    run("trunc_norm6",    32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h34000000, 8);
    run("ten_plus_one",   32'h41200000, 32'h3F800000, 1'b0, 32'h41300000, 3);
    run("diff20_align3",  32'h49800000, 32'h3FC00000, 1'b0, 32'h4980000C, 5);
    run("swap_sub",       32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 3);
    run("denorm_flush",   32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 3);
    run("underflow_neg",  32'h80C00000, 32'h80800000, 1'b1, 32'h80000000, 3);
`ifdef FP_ADD_SEQ_SPECIALS_EN
    run("inf_minus_inf",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1);
    run("inf_plus_one",   32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1);
    run("nan_operand",    32'h3F800000, 32'h7FC00001, 1'b0, 32'h7FC00000, 1);
`else
    run("inf_as_number",  32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3);
`endif

    // Overflow, then back-pressure with in_valid asserted and ignored
    start_op("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
    wait_done(lat);
    chk("overflow_lat", 32'(lat), 32'd3);
    chk("overflow_res", result, 32'h7F800000);
    a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_result", result, 32'h7F800000);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    finish_op("overflow");

    // Reset during NORM aborts with no output
    start_op("abort", 32'h3F800000, 32'h3F7FFFFF, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_result", result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (10) @(posedge clk);
    #1 chk("abort_no_output", {31'd0, out_valid}, 32'd0);
    run("after_abort",    32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
